// File: rtl/wallace_tree_multiplier.sv
// wallace_tree_multiplier: registered unsigned 5x5 Wallace-tree multiplier with ripple final adder
module wtm_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module wtm_ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);
    assign s  = a ^ b;
    assign co = a & b;
endmodule

module wtm_csa #(
    parameter logic [9:0] MA = '0,
    parameter logic [9:0] MB = '0,
    parameter logic [9:0] MC = '0
) (
    input  logic [9:0] a,
    input  logic [9:0] b,
    input  logic [9:0] c,
    output logic [9:0] s,
    output logic [9:0] co
);
    assign co[0] = 1'b0;
    assign s[9]  = a[9] ^ b[9] ^ c[9];
    // Masks mark columns that can hold a live bit; the cell choice per column follows them
    for (genvar j = 0; j < 9; j++) begin : g_col
        if (MA[j] && MB[j] && MC[j]) begin : g_fa
            wtm_fa u_fa (.a(a[j]), .b(b[j]), .ci(c[j]), .s(s[j]), .co(co[j+1]));
        end else if ((MA[j] && MB[j]) || (MA[j] && MC[j]) || (MB[j] && MC[j])) begin : g_ha
            logic x, y, z, hs;
            assign {x, y, z} = !MC[j] ? {a[j], b[j], c[j]} :
                               !MB[j] ? {a[j], c[j], b[j]} : {b[j], c[j], a[j]};
            wtm_ha u_ha (.a(x), .b(y), .s(hs), .co(co[j+1]));
            assign s[j] = hs ^ z;
        end else begin : g_pass
            assign s[j]    = a[j] ^ b[j] ^ c[j];
            assign co[j+1] = 1'b0;
        end
    end
endmodule

module wallace_tree_multiplier (
    input  logic       clock,
    input  logic       resetn,
    input  logic [4:0] in1,
    input  logic [4:0] in2,
    output logic [9:0] result,
    output logic       cout
);
    function automatic logic [9:0] cmask(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        return ((a & b) | (a & c) | (b & c)) << 1;
    endfunction
    localparam logic [9:0] M0 = 10'h01f;
    localparam logic [9:0] M1 = 10'h03e;
    localparam logic [9:0] M2 = 10'h07c;
    localparam logic [9:0] M3 = 10'h0f8;
    localparam logic [9:0] M4 = 10'h1f0;
    localparam logic [9:0] S1 = M0 | M1 | M2;
    localparam logic [9:0] C1 = cmask(M0, M1, M2);
    localparam logic [9:0] S2 = S1 | C1 | M3;
    localparam logic [9:0] C2 = cmask(S1, C1, M3);
    logic [9:0]  r [5];
    logic [9:0]  s1, c1, s2, c2, s3, c3, sum;
    logic [10:0] k;
    for (genvar i = 0; i < 5; i++) begin : g_pp
        assign r[i] = {5'b0, in1 & {5{in2[i]}}} << i;
    end
    wtm_csa #(.MA(M0), .MB(M1), .MC(M2)) u_st1 (.a(r[0]), .b(r[1]), .c(r[2]), .s(s1), .co(c1));
    wtm_csa #(.MA(S1), .MB(C1), .MC(M3)) u_st2 (.a(s1), .b(c1), .c(r[3]), .s(s2), .co(c2));
    wtm_csa #(.MA(S2), .MB(C2), .MC(M4)) u_st3 (.a(s2), .b(c2), .c(r[4]), .s(s3), .co(c3));
    assign k[0] = 1'b0;
    for (genvar j = 0; j < 10; j++) begin : g_rca
        wtm_fa u_fa (.a(s3[j]), .b(c3[j]), .ci(k[j]), .s(sum[j]), .co(k[j+1]));
    end
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) {cout, result} <= '0;
        else {cout, result} <= {k[10], sum};
endmodule

// File: tb/tb_wallace_tree_multiplier.sv
// tb_wallace_tree_multiplier: scoreboard bench, directed vectors plus exhaustive sweep
module tb_wallace_tree_multiplier;
    typedef struct packed {
        logic [4:0]  a;
        logic [4:0]  b;
        logic [10:0] e;
    } item_t;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [4:0] in1 = '0;
    logic [4:0] in2 = '0;
    logic [9:0] result;
    logic       cout;
    item_t      q [$];
    int         checks = 0;
    int         fails = 0;

    wallace_tree_multiplier dut (
        .clock (clock),
        .resetn(resetn),
        .in1   (in1),
        .in2   (in2),
        .result(result),
        .cout  (cout)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got cout=%0b result=%0d, expected cout=%0b result=%0d",
                     name, got[10], got[9:0], exp[10], exp[9:0]);
        end
    endtask

    task automatic apply(input logic [4:0] a, input logic [4:0] b, input logic [10:0] e);
        @(negedge clock);
        in1 = a;
        in2 = b;
        q.push_back('{a: a, b: b, e: e});
    endtask

    initial begin : monitor
        item_t it;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() != 0) begin
                it = q.pop_front();
                check($sformatf("prod %0d*%0d", it.a, it.b), {cout, result}, it.e);
            end
        end
    end

    initial begin : watchdog
        #150000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        #2;
        check("reset state", {cout, result}, 11'd0);
        repeat (2) @(posedge clock);
        #1;
        check("reset held", {cout, result}, 11'd0);
        @(negedge clock);
        resetn = 1'b1;
        apply(5'd3, 5'd8, 11'd24);
        apply(5'd20, 5'd0, 11'd0);
        apply(5'd25, 5'd16, 11'd400);
        apply(5'd31, 5'd1, 11'd31);
        apply(5'd31, 5'd31, 11'd961);
        apply(5'd5, 5'd6, 11'd30);
        apply(5'd13, 5'd17, 11'd221);
        apply(5'd0, 5'd31, 11'd0);
        for (int a = 0; a < 32; a++)
            for (int b = 0; b < 32; b++)
                apply(5'(a), 5'(b), 11'(a * b));
        apply(5'd31, 5'd31, 11'd961);
        @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        check("async reset", {cout, result}, 11'd0);
        @(negedge clock);
        in1 = 5'd29;
        in2 = 5'd27;
        repeat (2) @(posedge clock);
        #1;
        check("reset low across edges", {cout, result}, 11'd0);
        @(negedge clock);
        resetn = 1'b1;
        in1 = 5'd7;
        in2 = 5'd9;
        q.push_back('{a: 5'd7, b: 5'd9, e: 11'd63});
        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected results not observed, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
